// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline stage: holds fetched instructions and decodes MIPS-style fields from registered state.
// Build option: define DECODE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module if_id_decode_stage #(
  parameter logic [31:0] BUBBLE_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc_plus4,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [15:0] out_raw_immediate,
  output logic [31:0] out_jump_target,
  output logic        out_alu_signed,
  output logic        out_load_upper
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] in_pc4;
  logic        in_fire, out_fire;

  // pc+4 is computed on entry so the output side only reads registers.
  assign in_pc4    = in_pc + 32'd4;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;
  assign out_valid = valid_q;

`ifdef DECODE_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  logic        ready_q;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  assign in_ready = ready_q && !rst && !flush;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if (!valid_q) begin
      if (in_fire) begin
        valid_d = 1'b1;
        instr_d = in_instr;
        pc4_d   = in_pc4;
      end
    end else if (out_fire) begin
      // Skid entry is older than anything arriving now; it moves up first.
      if (skid_valid_q) begin
        instr_d      = skid_instr_q;
        pc4_d        = skid_pc4_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        instr_d = in_instr;
        pc4_d   = in_pc4;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc4_d   = in_pc4;
    end
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
    instr_q      <= instr_d;
    pc4_q        <= pc4_d;
    skid_instr_q <= skid_instr_d;
    skid_pc4_q   <= skid_pc4_d;
  end
`else
  assign in_ready = !rst && !flush && (!valid_q || out_ready);

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (in_fire) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc4_d   = in_pc4;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
  end
`endif

  logic [31:0] cur_instr;

  // Empty stage presents the bubble word so downstream sees a harmless decode.
  assign cur_instr         = valid_q ? instr_q : BUBBLE_WORD;
  assign out_pc_plus4      = valid_q ? pc4_q : 32'd0;
  assign out_opcode        = cur_instr[31:26];
  assign out_rs            = cur_instr[25:21];
  assign out_rt            = cur_instr[20:16];
  assign out_rd            = cur_instr[15:11];
  assign out_shamt         = cur_instr[10:6];
  assign out_funct         = cur_instr[5:0];
  assign out_raw_immediate = cur_instr[15:0];
  assign out_jump_target   = {out_pc_plus4[31:28], cur_instr[25:0], 2'b00};
  assign out_load_upper    = (out_opcode == 6'h0F);

  always_comb begin
    case (out_opcode)
      6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2A, 6'h2B: out_alu_signed = 1'b1;
      default:                    out_alu_signed = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed self-checking bench for if_id_decode_stage; honours DECODE_SKID_EN for the skid build.
module tb_if_id_decode_stage;

  localparam logic [31:0] BUBBLE = 32'h2102_3345;
`ifdef DECODE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc_plus4, out_jump_target;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_raw_immediate;
  logic        out_alu_signed, out_load_upper;

  int errors = 0;
  int checks = 0;

  if_id_decode_stage #(.BUBBLE_WORD(BUBBLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus4(out_pc_plus4), .out_opcode(out_opcode), .out_funct(out_funct),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_raw_immediate(out_raw_immediate), .out_jump_target(out_jump_target),
    .out_alu_signed(out_alu_signed), .out_load_upper(out_load_upper)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Every task begins and ends 1 time unit after a rising edge; samples are taken 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted (bounded), then drop in_valid.
  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    int n;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_accept: in_ready=%b want 1 for instr %h", in_ready, instr);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Pop the head entry; called at the sample point.
  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Keep offering instructions with out_ready=0 until in_ready drops; reports accepted count.
  task automatic fill(input logic [15:0] base, output int acc);
    acc = 0;
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1;
      in_instr = {6'h09, 5'd1, 5'd2, base + 16'(acc)};
      in_pc    = 32'h0000_5000 + 32'(4 * acc);
      #1;
      if (!in_ready) break;
      acc++;
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    tick();
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", out_pc_plus4); end
    checks++; if (out_opcode !== 6'h08) begin errors++; $display("FAIL reset_bubble_opcode: got %h want 08", out_opcode); end
    checks++; if (out_raw_immediate !== 16'h3345) begin errors++; $display("FAIL reset_bubble_imm: got %h want 3345", out_raw_immediate); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [8];
    logic [31:0] v_pc [8];
    logic [31:0] e_pc4 [8];
    logic [31:0] e_jt [8];
    logic [5:0]  e_op [8];
    logic [5:0]  e_fn [8];
    logic [4:0]  e_rs [8];
    logic [4:0]  e_rt [8];
    logic [4:0]  e_rd [8];
    logic [4:0]  e_sh [8];
    logic [15:0] e_imm [8];
    logic        e_sgn [8];
    logic        e_lui [8];
    // LUI, ADDI, ORI, R-type add, LW at pc wrap, J, BEQ, ANDI
    v_instr = '{32'h3C01_1234, 32'h2022_FFFF, 32'h3422_FFFF, 32'h00A6_4020,
                32'h8C22_0008, 32'h0800_0010, 32'h1022_0003, 32'h3042_00FF};
    v_pc    = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0000_1000,
                32'hFFFF_FFFC, 32'h8000_0000, 32'h0000_2000, 32'h0000_0000};
    e_pc4   = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0000_1004,
                32'h0000_0000, 32'h8000_0004, 32'h0000_2004, 32'h0000_0004};
    e_jt    = '{32'h0004_48D0, 32'h008B_FFFC, 32'h008B_FFFC, 32'h0299_0080,
                32'h0088_0020, 32'h8000_0040, 32'h0088_000C, 32'h0108_03FC};
    e_op    = '{6'h0F, 6'h08, 6'h0D, 6'h00, 6'h23, 6'h02, 6'h04, 6'h0C};
    e_fn    = '{6'h34, 6'h3F, 6'h3F, 6'h20, 6'h08, 6'h10, 6'h03, 6'h3F};
    e_rs    = '{5'd0, 5'd1, 5'd1, 5'd5, 5'd1, 5'd0, 5'd1, 5'd2};
    e_rt    = '{5'd1, 5'd2, 5'd2, 5'd6, 5'd2, 5'd0, 5'd2, 5'd2};
    e_rd    = '{5'd2, 5'd31, 5'd31, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    e_sh    = '{5'd8, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
    e_imm   = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h4020, 16'h0008, 16'h0010, 16'h0003, 16'h00FF};
    e_sgn   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_lui   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load(v_instr[i], v_pc[i]);
      #1;
      $display("decode[%0d] instr=%h pc=%h -> op=%h pc4=%h jt=%h sgn=%b lui=%b",
               i, v_instr[i], v_pc[i], out_opcode, out_pc_plus4, out_jump_target, out_alu_signed, out_load_upper);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_pc_plus4 !== e_pc4[i]) begin errors++; $display("FAIL decode_pc4[%0d]: got %h want %h", i, out_pc_plus4, e_pc4[i]); end
      checks++; if (out_jump_target !== e_jt[i]) begin errors++; $display("FAIL decode_jt[%0d]: got %h want %h", i, out_jump_target, e_jt[i]); end
      checks++; if (out_opcode !== e_op[i]) begin errors++; $display("FAIL decode_opcode[%0d]: got %h want %h", i, out_opcode, e_op[i]); end
      checks++; if (out_funct !== e_fn[i]) begin errors++; $display("FAIL decode_funct[%0d]: got %h want %h", i, out_funct, e_fn[i]); end
      checks++; if (out_rs !== e_rs[i]) begin errors++; $display("FAIL decode_rs[%0d]: got %0d want %0d", i, out_rs, e_rs[i]); end
      checks++; if (out_rt !== e_rt[i]) begin errors++; $display("FAIL decode_rt[%0d]: got %0d want %0d", i, out_rt, e_rt[i]); end
      checks++; if (out_rd !== e_rd[i]) begin errors++; $display("FAIL decode_rd[%0d]: got %0d want %0d", i, out_rd, e_rd[i]); end
      checks++; if (out_shamt !== e_sh[i]) begin errors++; $display("FAIL decode_shamt[%0d]: got %0d want %0d", i, out_shamt, e_sh[i]); end
      checks++; if (out_raw_immediate !== e_imm[i]) begin errors++; $display("FAIL decode_imm[%0d]: got %h want %h", i, out_raw_immediate, e_imm[i]); end
      checks++; if (out_alu_signed !== e_sgn[i]) begin errors++; $display("FAIL decode_signed[%0d]: got %b want %b", i, out_alu_signed, e_sgn[i]); end
      checks++; if (out_load_upper !== e_lui[i]) begin errors++; $display("FAIL decode_lui[%0d]: got %b want %b", i, out_load_upper, e_lui[i]); end
      drain();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_empty_valid: got %b want 0", out_valid); end
    checks++; if (out_raw_immediate !== 16'h3345) begin errors++; $display("FAIL decode_empty_imm: got %h want 3345", out_raw_immediate); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL decode_empty_pc4: got %h want 0", out_pc_plus4); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = {6'h09, 5'd3, 5'd4, 16'(k)};
      in_pc    = 32'h0000_0100 + 32'(4 * k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
      if (k > 0) begin
        $display("b2b[%0d] out_valid=%b imm=%h", k, out_valid, out_raw_immediate);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); end
        checks++; if (out_raw_immediate !== 16'(k - 1)) begin errors++; $display("FAIL b2b_imm[%0d]: got %h want %h", k, out_raw_immediate, 16'(k - 1)); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_raw_immediate !== 16'd3) begin errors++; $display("FAIL b2b_last: got valid=%b imm=%h want valid=1 imm=0003", out_valid, out_raw_immediate); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic        pat [4];
    int          sent, delivered, cyc;
    logic        prev_stall;
    logic [15:0] prev_imm;
    logic [31:0] prev_pc4;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; delivered = 0; cyc = 0; prev_stall = 1'b0;
    prev_imm = 16'h0; prev_pc4 = 32'h0;
    while (delivered < 8 && cyc < 100) begin
      in_valid  = (sent < 8);
      in_instr  = {6'h09, 5'd1, 5'd2, 16'h0100 + 16'(sent)};
      in_pc     = 32'h0000_3000 + 32'(4 * sent);
      out_ready = pat[cyc % 4];
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_raw_immediate !== prev_imm || out_pc_plus4 !== prev_pc4) begin
          errors++;
          $display("FAIL bp_stable[cyc %0d]: got valid=%b imm=%h pc4=%h want valid=1 imm=%h pc4=%h",
                   cyc, out_valid, out_raw_immediate, out_pc_plus4, prev_imm, prev_pc4);
        end
      end
      if (out_valid && out_ready) begin
        $display("bp deliver[%0d] imm=%h pc4=%h", delivered, out_raw_immediate, out_pc_plus4);
        checks++; if (out_raw_immediate !== 16'h0100 + 16'(delivered)) begin errors++; $display("FAIL bp_order_imm[%0d]: got %h want %h", delivered, out_raw_immediate, 16'h0100 + 16'(delivered)); end
        checks++; if (out_pc_plus4 !== 32'h0000_3004 + 32'(4 * delivered)) begin errors++; $display("FAIL bp_order_pc4[%0d]: got %h want %h", delivered, out_pc_plus4, 32'h0000_3004 + 32'(4 * delivered)); end
        delivered++;
      end
      prev_stall = out_valid && !out_ready;
      prev_imm   = out_raw_immediate;
      prev_pc4   = out_pc_plus4;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (delivered !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", delivered); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_fill();
    int acc;
    out_ready = 1'b0;
    fill(16'h0200, acc);
    $display("fill accepted %0d entries", acc);
    checks++; if (acc !== DEPTH) begin errors++; $display("FAIL fill_depth: got %0d want %0d", acc, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_raw_immediate !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL fill_drain[%0d]: got valid=%b imm=%h want valid=1 imm=%h", i, out_valid, out_raw_immediate, 16'h0200 + 16'(i)); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_flush();
    int acc;
    out_ready = 1'b0;
    fill(16'h0300, acc);
    checks++; if (acc !== DEPTH) begin errors++; $display("FAIL flush_fill: got %0d want %0d", acc, DEPTH); end
    in_valid = 1'b1;
    in_instr = {6'h09, 5'd1, 5'd2, 16'h03FF};
    flush    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    $display("flush held=%0d -> out_valid=%b imm=%h", acc, out_valid, out_raw_immediate);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_pc_plus4 !== 32'h0 || out_raw_immediate !== 16'h3345) begin errors++; $display("FAIL flush_bubble: got pc4=%h imm=%h want pc4=0 imm=3345", out_pc_plus4, out_raw_immediate); end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got valid=%b imm=%h want valid=0", i, out_valid, out_raw_immediate); end
      tick();
    end
    out_ready = 1'b0;
    // Output transfer coinciding with flush is still delivered.
    load({6'h09, 5'd1, 5'd2, 16'h03A0}, 32'h0000_6000);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_raw_immediate !== 16'h03A0) begin errors++; $display("FAIL flush_deliver: got valid=%b imm=%h want valid=1 imm=03a0", out_valid, out_raw_immediate); end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_after: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    int acc;
    out_ready = 1'b0;
    fill(16'h0400, acc);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = {6'h09, 5'd1, 5'd2, 16'h04FF};
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    checks++; if (out_raw_immediate !== 16'h3345 || out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rstmid_bubble: got imm=%h pc4=%h want imm=3345 pc4=0", out_raw_immediate, out_pc_plus4); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    tick();
    load({6'h09, 5'd1, 5'd2, 16'h04A0}, 32'h0000_7000);
    #1;
    $display("rstmid new: valid=%b imm=%h pc4=%h", out_valid, out_raw_immediate, out_pc_plus4);
    checks++; if (out_valid !== 1'b1 || out_raw_immediate !== 16'h04A0) begin errors++; $display("FAIL rstmid_first: got valid=%b imm=%h want valid=1 imm=04a0", out_valid, out_raw_immediate); end
    checks++; if (out_pc_plus4 !== 32'h0000_7004) begin errors++; $display("FAIL rstmid_pc4: got %h want 00007004", out_pc_plus4); end
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_fill();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_decode_stage.md
IF_ID_DECODE_STAGE -- requirements
Module: if_id_decode_stage

Interface
REQ-001 Parameter: BUBBLE_WORD, default 32'h0000_0000, instruction word presented in the field outputs while out_valid=0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  fetch presents an instruction this cycle.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_instr  input  32  fetched instruction word.
REQ-007 in_pc  input  32  address of in_instr.
REQ-008 flush  input  1  discard all held instructions (branch/jump redirect).
REQ-009 out_valid  output  1  decoded instruction available to the execute stage.
REQ-010 out_ready  input  1  execute stage accepts this cycle.
REQ-011 out_pc_plus4  output  32  held pc + 4, modulo 2^32.
REQ-012 out_opcode/out_funct  output  6 each  instr[31:26] / instr[5:0].
REQ-013 out_rs/out_rt/out_rd/out_shamt  output  5 each  instr[25:21] / [20:16] / [15:11] / [10:6].
REQ-014 out_raw_immediate  output  16  instr[15:0]; feeds the immediate-extension logic.
REQ-015 out_jump_target  output  32  {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-016 out_alu_signed  output  1  immediate is sign-extended before the ALU.
REQ-017 out_load_upper  output  1  immediate is placed in bits [31:16] before the ALU (LUI).

Function
REQ-018 A transfer occurs on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready, each sampled at the rising edge of clk.
REQ-019 The stage shall deliver instructions in order, losing none and duplicating none; latency from input transfer to out_valid is exactly 1 cycle when the stage is empty.
REQ-020 While out_valid=1 && out_ready=0, all out_* signals shall hold stable.
REQ-021 The field outputs (REQ-011..017) shall be registered or decoded only from registered state, with no combinational path from in_instr/in_pc.
REQ-022 out_load_upper=1 iff opcode==6'h0F.
REQ-023 out_alu_signed=1 iff opcode is in {08,09,0A,0B,04..07,20..25,28..2B} (hex); otherwise out_alu_signed=0, including ANDI 0C, ORI 0D, XORI 0E, LUI 0F and R-type 00.
REQ-024 While out_valid=0, the field outputs shall decode from BUBBLE_WORD, and out_pc_plus4 shall be 0.
REQ-025 Flush: on a cycle with flush=1, all held entries shall be invalidated at the edge, and out_valid shall be 0 in the next cycle.
REQ-026 Flush: in_ready shall be forced to 0 during a flush cycle, so no input transfer occurs.
REQ-027 Flush: an output transfer that coincides with the flush cycle shall still count as delivered.
REQ-028 Simultaneous input and output transfers in the same cycle shall be supported with no bubble inserted.

Reset
REQ-029 While rst=1 at an edge, all entries shall invalidate; afterwards out_valid=0, in_ready=0 during reset, and field outputs equal BUBBLE_WORD decode with out_pc_plus4=0.
REQ-030 rst shall take priority over flush and over all transfers.
REQ-031 in_ready shall be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro DECODE_SKID_EN, defined: the stage shall be a 2-entry skid buffer in which in_ready is a register output (1 iff the skid entry is empty), so full throughput is sustained with no combinational path from out_ready to in_ready.
REQ-033 Macro DECODE_SKID_EN, undefined: the stage shall be a single entry, with in_ready = !rst && !flush && (!out_valid || out_ready) (combinational).
REQ-034 All other requirements shall hold in both builds.

Verification
REQ-035 Decode check: instr 32'h3C01_1234 (LUI) at pc 32'h0040_0000 -> out_load_upper=1, out_alu_signed=0, out_raw_immediate=16'h1234, out_rt=1, out_pc_plus4=32'h0040_0004.
REQ-036 Decode check: instr 32'h2022_FFFF (ADDI) -> out_alu_signed=1, out_load_upper=0.
REQ-037 Decode check: instr 32'h3422_FFFF (ORI) -> out_alu_signed=0.
REQ-038 Backpressure: stream 8 instructions with out_ready toggling 1,0,0,1… -> all 8 arrive in order, outputs are stable while stalled, and the skid build accepts 2 entries before in_ready=0.
REQ-039 Wrap-around: in_pc=32'hFFFF_FFFC -> out_pc_plus4=0.
REQ-040 Jump target: in_pc=32'h8000_0000, instr 32'h0800_0010 -> out_jump_target=32'h8000_0040.
REQ-041 Flush with 2 held entries, out_ready=0 -> next cycle out_valid=0, and neither flushed instruction ever appears on the output.
REQ-042 Reset mid-stream -> out_valid=0 with bubble fields, and after release the first new instruction appears 1 cycle after acceptance.
REQ-043 All Verification scenarios shall be run with DECODE_SKID_EN both defined and undefined.
